// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM access controller.
package ct_spsram_ctrl_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/ct_spsram_512x7_ctrl.sv
// Single-port SRAM access controller: init sweep, read/masked-write arbitration
// with read anti-starvation, and a 1-cycle registered read response.
module ct_spsram_512x7_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH   = 9,
    parameter int unsigned            DATA_WIDTH   = 7,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE   = '0,
    parameter int unsigned            STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_rsp_vld,
    output logic [DATA_WIDTH-1:0] rd_rsp_data,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    output logic                  wr_gnt,
    input  logic                  init_req,
    output logic                  init_busy,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   sweep;
    logic [ADDR_WIDTH-1:0]   last_a;
    logic [DATA_WIDTH-1:0]   last_d;
    logic [STARVE_W-1:0]     starve;
    logic                    rsp_vld;
    logic                    run;
    logic                    starved;

    // Grants are same-cycle and never issued while reset is asserted.
    always_comb begin
        run     = !RST && (state == RUN);
        starved = (starve == LIMIT);
        rd_gnt  = run && rd_req && (!wr_req || starved);
        wr_gnt  = run && wr_req && !rd_gnt;
    end

    // Address and data hold their last driven values on idle cycles.
    always_comb begin
        sram_a    = last_a;
        sram_d    = last_d;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        if (RST) begin
            sram_a = '0;
            sram_d = '0;
        end else if (state == INIT) begin
            sram_a    = sweep;
            sram_d    = INIT_VALUE;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
        end else if (rd_gnt) begin
            sram_a   = rd_addr;
            sram_cen = 1'b0;
        end else if (wr_gnt) begin
            sram_a    = wr_addr;
            sram_d    = wr_data;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~wr_mask;
        end
    end

    always_comb begin
        init_busy   = RST || (state == INIT);
        rd_rsp_vld  = rsp_vld && !RST;
        rd_rsp_data = rd_rsp_vld ? sram_q : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= INIT;
            sweep   <= '0;
            starve  <= '0;
            rsp_vld <= 1'b0;
            last_a  <= '0;
            last_d  <= '0;
        end else begin
            rsp_vld <= rd_gnt;
            if (!sram_cen) begin
                last_a <= sram_a;
                last_d <= sram_d;
            end
            case (state)
                INIT: begin
                    starve <= '0;
                    sweep  <= sweep + ADDR_WIDTH'(1);
                    if (sweep == '1) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (rd_gnt) begin
                        starve <= '0;
                    end else if (rd_req && !starved) begin
                        starve <= starve + STARVE_W'(1);
                    end
                    if (init_req) begin
                        state <= INIT;
                        sweep <= '0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ct_spsram_512x7_ctrl.sv
// Self-checking bench for ct_spsram_512x7_ctrl with a behavioural SRAM and reference memory.
module tb_ct_spsram_512x7_ctrl;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 7;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned LIMIT = 4;
    localparam logic [DW-1:0] INITV = 7'h00;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_gnt;
    logic          rd_rsp_vld;
    logic [DW-1:0] rd_rsp_data;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] wr_mask = '0;
    logic          wr_gnt;
    logic          init_req = 1'b0;
    logic          init_busy;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q = '0;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];

    always #5 CLK = ~CLK;

    ct_spsram_512x7_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .INIT_VALUE  (INITV),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_rsp_vld (rd_rsp_vld),
        .rd_rsp_data(rd_rsp_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .wr_gnt     (wr_gnt),
        .init_req   (init_req),
        .init_busy  (init_busy),
        .sram_a     (sram_a),
        .sram_cen   (sram_cen),
        .sram_gwen  (sram_gwen),
        .sram_wen   (sram_wen),
        .sram_d     (sram_d),
        .sram_q     (sram_q)
    );

    // Behavioural single-port SRAM with active-low enables.
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            end else begin
                sram_q <= sram_mem[sram_a];
            end
        end
    end

    function automatic void ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [DW-1:0] m);
        ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
    endfunction

    function automatic void ref_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = INITV;
    endfunction

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [DW-1:0] m, output bit ok,
                               output logic [DW-1:0] wen_seen);
        ok = 1'b0;
        wen_seen = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            wr_req = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
            #1;
            if (wr_gnt) begin
                ok = 1'b1;
                wen_seen = sram_wen;
                ref_write(a, d, m);
                break;
            end
        end
        tick();
        wr_req = 1'b0;
        #1;
    endtask

    task automatic issue_read(input logic [AW-1:0] a, output bit ok, output logic vld_at_gnt,
                              output logic vld, output logic [DW-1:0] data);
        ok = 1'b0;
        vld_at_gnt = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            rd_req = 1'b1; rd_addr = a;
            #1;
            if (rd_gnt) begin
                ok = 1'b1;
                vld_at_gnt = rd_rsp_vld;
                break;
            end
        end
        tick();
        rd_req = 1'b0;
        #1;
        vld  = rd_rsp_vld;
        data = rd_rsp_data;
    endtask

    task automatic test_reset();
        bit ok;
        logic vg, v;
        logic [DW-1:0] q;
        logic [30:0] exp_rst;
        exp_rst = {1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 7'h7F, 1'b1, 9'h000, 7'h00};
        for (int c = 0; c < 3; c++) begin
            tick();
            RST = 1'b1; rd_req = 1'b1; wr_req = 1'b1; init_req = 1'b1;
            rd_addr = AW'($urandom); wr_addr = AW'($urandom); wr_data = DW'($urandom);
            wr_mask = '1;
            #1;
            total_cnt++;
            if ({rd_gnt, wr_gnt, rd_rsp_vld, rd_rsp_data, sram_cen, sram_gwen, sram_wen,
                 init_busy, sram_a, sram_d} !== exp_rst)
                $display("FAIL reset_gating: got %h expected %h",
                         {rd_gnt, wr_gnt, rd_rsp_vld, rd_rsp_data, sram_cen, sram_gwen,
                          sram_wen, init_busy, sram_a, sram_d}, exp_rst);
            else pass_cnt++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            if (i == 0) begin
                RST = 1'b0; rd_req = 1'b0; wr_req = 1'b0; init_req = 1'b0;
            end
            #1;
            total_cnt++;
            if ({sram_cen, sram_gwen, sram_wen, sram_a, sram_d, init_busy, rd_gnt, wr_gnt} !==
                {1'b0, 1'b0, 7'h00, AW'(i), INITV, 1'b1, 1'b0, 1'b0})
                $display("FAIL sweep_T%0d: a=%h cen=%b gwen=%b wen=%h d=%h busy=%b expected a=%h",
                         i, sram_a, sram_cen, sram_gwen, sram_wen, sram_d, init_busy, AW'(i));
            else pass_cnt++;
        end
        tick();
        #1;
        total_cnt++;
        if ({init_busy, sram_cen} !== 2'b01)
            $display("FAIL sweep_end_T512: busy=%b cen=%b expected busy=0 cen=1",
                     init_busy, sram_cen);
        else pass_cnt++;
        ref_clear();
        issue_read(9'h1A5, ok, vg, v, q);
        total_cnt++;
        if (!ok || v !== 1'b1 || q !== ref_mem[9'h1A5])
            $display("FAIL read_after_init: gnt=%b vld=%b data=%h expected %h",
                     ok, v, q, ref_mem[9'h1A5]);
        else pass_cnt++;
    endtask

    task automatic test_masked_write();
        bit ok1, ok2, okr;
        logic [DW-1:0] wen1, wen2, q;
        logic vg, v;
        issue_write(9'h010, 7'h7F, 7'h7F, ok1, wen1);
        issue_write(9'h010, 7'h00, 7'h05, ok2, wen2);
        total_cnt++;
        if (!ok1 || !ok2 || wen1 !== 7'h00 || wen2 !== 7'h7A)
            $display("FAIL masked_write_wen: gnt=%b%b wen=%h,%h expected 00,7a",
                     ok1, ok2, wen1, wen2);
        else pass_cnt++;
        issue_read(9'h010, okr, vg, v, q);
        total_cnt++;
        if (!okr || vg !== 1'b0 || v !== 1'b1 || q !== ref_mem[9'h010] || q !== 7'h7A)
            $display("FAIL masked_read: gnt=%b vld_at_gnt=%b vld=%b data=%h expected %h",
                     okr, vg, v, q, ref_mem[9'h010]);
        else pass_cnt++;
    endtask

    task automatic test_starvation();
        logic exp_rd;
        logic pend_vld;
        logic [DW-1:0] pend_data;
        pend_vld = 1'b0;
        pend_data = '0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            rd_req = 1'b1; rd_addr = AW'($urandom_range(0, 31));
            wr_req = 1'b1; wr_addr = AW'($urandom_range(0, 31));
            wr_data = DW'($urandom); wr_mask = DW'($urandom);
            #1;
            exp_rd = ((i % (LIMIT + 1)) == 0);
            total_cnt++;
            if (rd_gnt !== exp_rd || wr_gnt !== !exp_rd)
                $display("FAIL starve_cycle%0d: rd_gnt=%b wr_gnt=%b expected %b %b",
                         i, rd_gnt, wr_gnt, exp_rd, !exp_rd);
            else pass_cnt++;
            total_cnt++;
            if (rd_rsp_vld !== pend_vld || rd_rsp_data !== (pend_vld ? pend_data : 7'h00))
                $display("FAIL starve_rsp%0d: vld=%b data=%h expected %b %h",
                         i, rd_rsp_vld, rd_rsp_data, pend_vld, pend_data);
            else pass_cnt++;
            pend_vld = exp_rd;
            if (exp_rd) pend_data = ref_mem[rd_addr];
            else ref_write(wr_addr, wr_data, wr_mask);
        end
        tick();
        rd_req = 1'b0; wr_req = 1'b0;
        #1;
        total_cnt++;
        if (rd_rsp_vld !== pend_vld || rd_rsp_data !== (pend_vld ? pend_data : 7'h00))
            $display("FAIL starve_last_rsp: vld=%b data=%h expected %b %h",
                     rd_rsp_vld, rd_rsp_data, pend_vld, pend_data);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int unsigned denied;
        logic erd, ewr, pend_vld;
        logic [DW-1:0] pend_data;
        denied = 0;
        pend_vld = 1'b0;
        pend_data = '0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            rd_req  = ($urandom_range(0, 99) < 60);
            wr_req  = ($urandom_range(0, 99) < 70);
            rd_addr = AW'($urandom_range(0, 31));
            wr_addr = AW'($urandom_range(0, 31));
            wr_data = DW'($urandom);
            wr_mask = ($urandom_range(0, 9) == 0) ? 7'h00 : DW'($urandom);
            #1;
            total_cnt++;
            if (rd_rsp_vld !== pend_vld || rd_rsp_data !== (pend_vld ? pend_data : 7'h00))
                $display("FAIL rand_rsp_c%0d: vld=%b data=%h expected %b %h",
                         c, rd_rsp_vld, rd_rsp_data, pend_vld, pend_data);
            else pass_cnt++;
            erd = rd_req && (!wr_req || denied >= LIMIT);
            ewr = wr_req && !erd;
            total_cnt++;
            if ({rd_gnt, wr_gnt, sram_cen} !== {erd, ewr, !(erd || ewr)})
                $display("FAIL rand_gnt_c%0d: rd=%b wr=%b cen=%b expected %b %b %b",
                         c, rd_gnt, wr_gnt, sram_cen, erd, ewr, !(erd || ewr));
            else pass_cnt++;
            pend_vld = erd;
            if (erd) pend_data = ref_mem[rd_addr];
            if (ewr) ref_write(wr_addr, wr_data, wr_mask);
            if (erd) denied = 0;
            else if (rd_req && denied < LIMIT) denied++;
        end
        tick();
        rd_req = 1'b0; wr_req = 1'b0;
        #1;
        total_cnt++;
        if (rd_rsp_vld !== pend_vld || rd_rsp_data !== (pend_vld ? pend_data : 7'h00))
            $display("FAIL rand_last_rsp: vld=%b data=%h expected %b %h",
                     rd_rsp_vld, rd_rsp_data, pend_vld, pend_data);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic pend_vld;
        logic [DW-1:0] pend_data;
        pend_vld = 1'b0;
        pend_data = '0;
        for (int i = 0; i < 9; i++) begin
            tick();
            rd_req = (i < 8);
            rd_addr = AW'($urandom_range(0, 31));
            #1;
            total_cnt++;
            if (rd_gnt !== (i < 8) || rd_rsp_vld !== pend_vld ||
                rd_rsp_data !== (pend_vld ? pend_data : 7'h00))
                $display("FAIL b2b_c%0d: gnt=%b vld=%b data=%h expected %b %b %h",
                         i, rd_gnt, rd_rsp_vld, rd_rsp_data, (i < 8), pend_vld, pend_data);
            else pass_cnt++;
            pend_vld = (i < 8);
            pend_data = ref_mem[rd_addr];
        end
        rd_req = 1'b0;
    endtask

    task automatic test_idle();
        bit okw, okr;
        logic [DW-1:0] wen, wd, q;
        logic vg, v;
        wd = DW'($urandom);
        issue_write(9'h0C3, wd, 7'h7F, okw, wen);
        issue_read(9'h044, okr, vg, v, q);
        total_cnt++;
        if (!okw || !okr || v !== 1'b1 || q !== ref_mem[9'h044])
            $display("FAIL idle_setup: wgnt=%b rgnt=%b vld=%b data=%h expected %h",
                     okw, okr, v, q, ref_mem[9'h044]);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            total_cnt++;
            if ({sram_cen, sram_a, sram_d, rd_rsp_vld, rd_gnt, wr_gnt} !==
                {1'b1, 9'h044, wd, 1'b0, 1'b0, 1'b0})
                $display("FAIL idle_c%0d: cen=%b a=%h d=%h vld=%b expected 1 044 %h 0",
                         i, sram_cen, sram_a, sram_d, rd_rsp_vld, wd);
            else pass_cnt++;
        end
    endtask

    task automatic test_reinit();
        bit okw;
        logic [DW-1:0] wen;
        issue_write(9'h003, 7'h55, 7'h7F, okw, wen);
        tick();
        rd_req = 1'b1; rd_addr = 9'h003; init_req = 1'b1;
        #1;
        total_cnt++;
        if (!okw || rd_gnt !== 1'b1)
            $display("FAIL reinit_grant: wgnt=%b rd_gnt=%b expected 1 1", okw, rd_gnt);
        else pass_cnt++;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            init_req = (i == 100);
            rd_req = 1'b1; wr_req = 1'b1;
            wr_addr = 9'h003; wr_data = DW'($urandom); wr_mask = '1;
            #1;
            if (i == 0) begin
                total_cnt++;
                if (rd_rsp_vld !== 1'b1 || rd_rsp_data !== ref_mem[9'h003])
                    $display("FAIL reinit_rsp: vld=%b data=%h expected 1 %h",
                             rd_rsp_vld, rd_rsp_data, ref_mem[9'h003]);
                else pass_cnt++;
            end
            total_cnt++;
            if ({rd_gnt, wr_gnt, init_busy, sram_cen, sram_a} !== {1'b0, 1'b0, 1'b1, 1'b0, AW'(i)})
                $display("FAIL reinit_sweep_T%0d: rd=%b wr=%b busy=%b cen=%b a=%h expected a=%h",
                         i, rd_gnt, wr_gnt, init_busy, sram_cen, sram_a, AW'(i));
            else pass_cnt++;
        end
        ref_clear();
        tick();
        init_req = 1'b0; wr_req = 1'b0; rd_req = 1'b1; rd_addr = 9'h003;
        #1;
        total_cnt++;
        if (init_busy !== 1'b0 || rd_gnt !== 1'b1)
            $display("FAIL reinit_end: busy=%b rd_gnt=%b expected 0 1", init_busy, rd_gnt);
        else pass_cnt++;
        tick();
        rd_req = 1'b0;
        #1;
        total_cnt++;
        if (rd_rsp_vld !== 1'b1 || rd_rsp_data !== ref_mem[9'h003])
            $display("FAIL reinit_read: vld=%b data=%h expected 1 %h",
                     rd_rsp_vld, rd_rsp_data, ref_mem[9'h003]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        tick();
        rd_req = 1'b1; rd_addr = 9'h005;
        #1;
        total_cnt++;
        if (rd_gnt !== 1'b1) $display("FAIL midrd_grant: rd_gnt=%b expected 1", rd_gnt);
        else pass_cnt++;
        tick();
        rd_req = 1'b0; RST = 1'b1;
        #1;
        total_cnt++;
        if ({rd_rsp_vld, rd_rsp_data, sram_cen, init_busy} !== {1'b0, 7'h00, 1'b1, 1'b1})
            $display("FAIL midrd_drop: vld=%b data=%h cen=%b busy=%b expected 0 00 1 1",
                     rd_rsp_vld, rd_rsp_data, sram_cen, init_busy);
        else pass_cnt++;
        for (int i = 0; i <= 200; i++) begin
            tick();
            if (i == 0) RST = 1'b0;
            #1;
            if (i == 200) begin
                total_cnt++;
                if (sram_a !== 9'd200 || init_busy !== 1'b1)
                    $display("FAIL midsweep_pos: a=%h busy=%b expected 0c8 1", sram_a, init_busy);
                else pass_cnt++;
            end
        end
        tick();
        RST = 1'b1;
        #1;
        total_cnt++;
        if ({sram_cen, sram_a, init_busy} !== {1'b1, 9'h000, 1'b1})
            $display("FAIL midsweep_rst: cen=%b a=%h busy=%b expected 1 000 1",
                     sram_cen, sram_a, init_busy);
        else pass_cnt++;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            if (i == 0) RST = 1'b0;
            #1;
            total_cnt++;
            if ({sram_cen, sram_a, init_busy} !== {1'b0, AW'(i), 1'b1})
                $display("FAIL resweep_T%0d: cen=%b a=%h busy=%b expected a=%h",
                         i, sram_cen, sram_a, init_busy, AW'(i));
            else pass_cnt++;
        end
        tick();
        #1;
        total_cnt++;
        if (init_busy !== 1'b0)
            $display("FAIL resweep_end: busy=%b expected 0", init_busy);
        else pass_cnt++;
        ref_clear();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i] = DW'($urandom_range(1, 127));
            ref_mem[i]  = 'x;
        end
        test_reset();
        test_masked_write();
        test_starvation();
        test_random();
        test_back_to_back();
        test_idle();
        test_reinit();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
